// File: rtl/dm_arbiter_if.sv
// Request/response bundle for one requester of dm_arbiter.
// The requester drives the request fields; the arbiter returns grant and load results.
interface dm_arbiter_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        is_unsigned;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, size, is_unsigned, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, size, is_unsigned, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access formatter for the byte-addressed data memory.
// Port C has priority; a starvation counter forces a grant to port D.
module dm_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   dm_arbiter_if.slave         c_io,
   dm_arbiter_if.slave         d_io,
   output logic [3:0]          m_wea_o,
   output logic [9:0]          m_addra_o,
   output logic [31:0]         m_dina_o,
   input  logic [31:0]         m_douta_i
);

   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   function automatic logic access_legal(input logic [1:0] size, input logic [9:0] addr);
      logic [10:0] last;
      logic        ok;
      last = {1'b0, addr};
      ok   = 1'b1;
      case (size)
         2'b00:   last = {1'b0, addr};
         2'b01:   last = {1'b0, addr} + 11'd1;
         2'b10:   last = {1'b0, addr} + 11'd3;
         default: ok = 1'b0;
      endcase
      return ok && (last <= 11'd1023);
   endfunction

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                          input logic is_unsigned);
      case (size)
         2'b00:   return is_unsigned ? {24'h0, data[7:0]} : {{24{data[7]}}, data[7:0]};
         2'b01:   return is_unsigned ? {16'h0, data[15:0]} : {{16{data[15]}}, data[15:0]};
         2'b10:   return data;
         default: return 32'h0;
      endcase
   endfunction

   logic [3:0]  wait_q, wait_d;
   logic        c_gnt, d_gnt;
   logic        sel_we, sel_unsigned, sel_legal;
   logic [1:0]  sel_size;
   logic [31:0] load_data;
   logic        c_rvalid_q, c_rvalid_d, c_err_q, c_err_d;
   logic        d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [31:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

   // Grants are suppressed during reset so a store in flight is cancelled.
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!rst) begin
         if (d_io.req && ((wait_q == Limit) || !c_io.req)) begin
            d_gnt = 1'b1;
         end else if (c_io.req) begin
            c_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      wait_d = wait_q;
      if (!d_io.req || d_gnt) begin
         wait_d = 4'd0;
      end else if (wait_q < Limit) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_comb begin
      sel_we       = d_gnt ? d_io.we          : c_io.we;
      sel_size     = d_gnt ? d_io.size        : c_io.size;
      sel_unsigned = d_gnt ? d_io.is_unsigned : c_io.is_unsigned;
      m_addra_o    = d_gnt ? d_io.addr        : c_io.addr;
      m_dina_o     = d_gnt ? d_io.wdata       : c_io.wdata;
      sel_legal    = access_legal(sel_size, m_addra_o);
      load_data    = extend(m_douta_i, sel_size, sel_unsigned);
      m_wea_o      = 4'b0000;
      if ((c_gnt || d_gnt) && sel_we && sel_legal) begin
         m_wea_o = size_mask(sel_size);
      end
   end

   // Rejected loads still return rvalid, with zero data.
   always_comb begin
      c_rvalid_d = c_gnt && !c_io.we;
      c_err_d    = c_gnt && !sel_legal;
      c_rdata_d  = (c_rvalid_d && sel_legal) ? load_data : 32'h0;
      d_rvalid_d = d_gnt && !d_io.we;
      d_err_d    = d_gnt && !sel_legal;
      d_rdata_d  = (d_rvalid_d && sel_legal) ? load_data : 32'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q     <= 4'd0;
         c_rvalid_q <= 1'b0;
         c_err_q    <= 1'b0;
         c_rdata_q  <= 32'h0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= 32'h0;
      end else begin
         wait_q     <= wait_d;
         c_rvalid_q <= c_rvalid_d;
         c_err_q    <= c_err_d;
         c_rdata_q  <= c_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign c_io.gnt    = c_gnt;
   assign c_io.rvalid = c_rvalid_q;
   assign c_io.rdata  = c_rdata_q;
   assign c_io.err    = c_err_q;
   assign d_io.gnt    = d_gnt;
   assign d_io.rvalid = d_rvalid_q;
   assign d_io.rdata  = d_rdata_q;
   assign d_io.err    = d_err_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access formatter in front of the byte-addressed data memory `dm`. It shares the single `dm` port between the CPU load/store path (port C) and a debug/loader path (port D). It converts size/sign requests into `wea` byte enables, zero- or sign-extended load data and bounds checks. Port C has priority, and a starvation counter guarantees progress for port D.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive cycles port D may wait before it is forced a grant (range 1..15).
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `c_req` / `d_req` in 1: access request.
- `c_we` / `d_we` in 1: 1 = store, 0 = load.
- `c_size` / `d_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `c_unsigned` / `d_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `c_addr` / `d_addr` in 10: byte address; any alignment is allowed.
- `c_wdata` / `d_wdata` in 32: store data, LSB-justified.
- `c_gnt` / `d_gnt` out 1: combinational; the access is consumed at this clock edge.
- `c_rvalid` / `d_rvalid` out 1: load data valid, registered.
- `c_rdata` / `d_rdata` out 32: extended load data, registered.
- `c_err` / `d_err` out 1: one-cycle pulse flagging a rejected access, registered.
- `m_wea` out 4: to `dm` `wea`.
- `m_addra` out 10: to `dm` `addra`.
- `m_dina` out 32: to `dm` `dina`.
- `m_douta` in 32: from `dm` `douta`; combinational read of bytes addr..addr+3.

## Operation
- **Arbitration, evaluated every cycle:**
  - Grant D if `d_req` and `wait_cnt == STARVE_LIMIT`.
  - Otherwise grant C if `c_req`.
  - Otherwise grant D if `d_req`.
  - At most one grant per cycle.
- **Starvation counter** `wait_cnt` (4 bits):
  - Increments when `d_req` is high and `d_gnt` is low.
  - Clears when `d_gnt` is high or `d_req` is low.
  - Saturates at `STARVE_LIMIT`.
- **Mux:** `m_addra` = granted port's address. With no grant, `m_addra` holds the C address and `m_wea` = 0.
- **Legality:** an access is illegal if size = 11, or if addr + nbytes − 1 > 1023, where nbytes is 1, 2 or 4.
  - An illegal access is still granted (consumed).
  - It forces `m_wea` = 0.
  - The next cycle it pulses `err` for that port and also `rvalid` if it was a load, with `rdata` = 0.
- **Store, legal:** `m_wea` = 0001 / 0011 / 1111 for byte / half / word, and `m_dina` = wdata unshifted. `dm` offsets the bytes internally.
- **Load, legal:** `m_wea` = 0. At the edge, capture `m_douta` masked to nbytes and extended from bit 7 / 15 / 31, then set `rvalid` for the next cycle.
- Requesters hold all request fields stable while `req` is high and `gnt` is low. A requester may drop `req` without penalty.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - `wait_cnt` = 0.
  - All `rvalid`, `err` = 0; all `rdata` = 0.
  - `c_gnt`, `d_gnt` forced 0 and `m_wea` forced 0 while `rst` is high.
  - Reset during a grant cycle cancels that access; no write occurs.
- **Grant:** same-cycle, combinational from `req` and `wait_cnt`.
- **Store:** committed into `dm` at the rising edge that ends the grant cycle.
- **Load latency:** 1 cycle. `rvalid` and `rdata` are valid for exactly the cycle after the grant, then `rvalid` returns to 0 unless the port is granted a load again.
- **Back-to-back:** a port may be granted every cycle.
- **Read-after-write:** a load in cycle N+1 to an address stored in cycle N returns the new data.
- **Simultaneous requests:** C wins for STARVE_LIMIT cycles, then D wins in the next cycle. C's request stays pending, ungranted, and is granted the following cycle.
- **Wrap:** the address never wraps. Word at 1021 is illegal; byte at 1023 is legal; half at 1022 is legal.

## Test plan
- **Reset:** assert `rst` mid-store with `c_req` = 1, `c_we` = 1, addr 0x010. Required: `m_wea` = 0, no write occurs, all registered outputs are 0, and a subsequent load of 0x010 returns the old data.
- **Store/load formatting:**
  - C stores word 0x80FF7F01 at 0x005.
  - Load byte at 0x006, signed: returns 0x0000007F.
  - Load byte at 0x007, signed: returns 0xFFFFFFFF.
  - Load half at 0x007, unsigned: returns 0x000080FF.
  - Load word at 0x005: returns 0x80FF7F01.
- **Starvation** (STARVE_LIMIT = 4): `c_req` and `d_req` both held high continuously. Required: grant pattern C,C,C,C,D,C,C,C,C,D…; `wait_cnt` clears after each D grant.
- **Bounds:**
  - D word load at 0x3FD → grant; next cycle `d_err` = 1, `d_rvalid` = 1, `d_rdata` = 0.
  - D byte store at 0x3FF with data 0xA5 → no `err`; a byte load at 0x3FF returns 0x000000A5.
  - C access with size = 11 → `c_err` pulses and memory is unchanged.
- **Read-after-write across ports:** D stores half 0x1234 at 0x100 in cycle N; C loads half at 0x100 in cycle N+1. Required: `c_rvalid` in N+2 with `c_rdata` = 0x00001234.
- **Idle:** no requests for 10 cycles. Required: `m_wea` = 0 every cycle, no `rvalid` or `err` pulses, and `wait_cnt` remains 0.
